fadd_normalizer: RTL and testbench

- Post-add normalization stage of the floating-point adder datapath; sits directly downstream of the 16-bit mantissa adder.
- Consumes the adder's 17-bit raw result (carry plus sum), the pre-aligned common exponent and the result sign.
- Renormalizes the mantissa so the leading 1 sits at bit MW-1, using an iterative one-bit-per-cycle shift FSM.
- Adjusts the exponent, flags zero/overflow/underflow, and hands the result on with a valid/ready handshake.

---
 rtl/fadd_normalizer.sv | 233 +++++++++++++++++++++++
 tb/tb_fadd_normalizer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fadd_normalizer.sv
// Post-add normalizer: shifts the mantissa adder result left one bit per cycle until normalized.
// Optional round-to-nearest-even stage enabled by the FADD_NORM_ROUND_EN macro.
module fadd_normalizer #(
  parameter int MW = 16,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [MW:0]   in_sum,
  input  logic [EW-1:0] in_exp,
  input  logic          in_sgn,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [MW-1:0] out_mant,
  output logic [EW-1:0] out_exp,
  output logic          out_sgn,
  output logic          out_zero,
  output logic          out_ovf,
  output logic          out_unf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [EW-1:0] EXP_MAX  = {EW{1'b1}};
  localparam logic [EW-1:0] EXP_ONE  = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [EW-1:0] EXP_ZERO = {EW{1'b0}};
  // Any exponent at or above this value overflows once incremented.
  localparam logic [EW-1:0] EXP_OVF_TH = EXP_MAX - EXP_ONE;
  localparam logic [MW-1:0] MANT_ZERO  = {MW{1'b0}};
  localparam logic [MW:0]   SUM_ZERO   = {(MW+1){1'b0}};

`ifdef FADD_NORM_ROUND_EN
  localparam state_t POST = ROUND;
  localparam logic [MW:0]   MANT_INC = {{MW{1'b0}}, 1'b1};
  localparam logic [MW-1:0] MANT_MSB = {1'b1, {(MW-1){1'b0}}};
`else
  localparam state_t POST = DONE;
`endif

  state_t        state_r;
  state_t        next_state_s;
  logic [MW-1:0] mant_r;
  logic [EW-1:0] exp_r;
  logic          sgn_r;
  logic          zero_r;
  logic          ovf_r;
  logic          unf_r;
  logic          norm_stop_s;

`ifdef FADD_NORM_ROUND_EN
  logic          guard_r;
  logic [MW:0]   round_sum_s;
  logic          round_up_s;
`endif

  // NORM finishes when the leading one is in place or the exponent bottoms out.
  always_comb begin
    norm_stop_s = mant_r[MW-1] || (exp_r == EXP_ZERO);
  end

`ifdef FADD_NORM_ROUND_EN
  // Rounding increment and tie-to-even decision from the guard bit.
  always_comb begin
    round_sum_s = {1'b0, mant_r} + MANT_INC;
    round_up_s  = guard_r && mant_r[0] && !ovf_r && !zero_r;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          if (in_sum[MW] || (in_sum == SUM_ZERO)) begin
            next_state_s = POST;
          end else begin
            next_state_s = NORM;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      NORM: begin
        if (norm_stop_s) begin
          next_state_s = POST;
        end else begin
          next_state_s = NORM;
        end
      end
      ROUND: begin
        next_state_s = DONE;
      end
      DONE: begin
        if (out_ready) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      DONE: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, iterative shift and optional rounding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mant_r  <= MANT_ZERO;
      exp_r   <= EXP_ZERO;
      sgn_r   <= 1'b0;
      zero_r  <= 1'b0;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
`ifdef FADD_NORM_ROUND_EN
      guard_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            sgn_r   <= in_sgn;
            zero_r  <= 1'b0;
            ovf_r   <= 1'b0;
            unf_r   <= 1'b0;
`ifdef FADD_NORM_ROUND_EN
            guard_r <= 1'b0;
`endif
            if (in_sum[MW]) begin
              if (in_exp >= EXP_OVF_TH) begin
                ovf_r  <= 1'b1;
                exp_r  <= EXP_MAX;
                mant_r <= MANT_ZERO;
              end else begin
                mant_r  <= in_sum[MW:1];
                exp_r   <= in_exp + EXP_ONE;
`ifdef FADD_NORM_ROUND_EN
                guard_r <= in_sum[0];
`endif
              end
            end else if (in_sum == SUM_ZERO) begin
              mant_r <= MANT_ZERO;
              exp_r  <= EXP_ZERO;
              sgn_r  <= 1'b0;
              zero_r <= 1'b1;
            end else begin
              mant_r <= in_sum[MW-1:0];
              exp_r  <= in_exp;
            end
          end
        end
        NORM: begin
          if (mant_r[MW-1]) begin
            mant_r <= mant_r;
          end else if (exp_r == EXP_ZERO) begin
            unf_r <= 1'b1;
          end else begin
            mant_r <= {mant_r[MW-2:0], 1'b0};
            exp_r  <= exp_r - EXP_ONE;
          end
        end
`ifdef FADD_NORM_ROUND_EN
        ROUND: begin
          guard_r <= 1'b0;
          if (round_up_s) begin
            if (round_sum_s[MW]) begin
              // Mantissa wrapped to 1.000..: renormalize and recheck overflow.
              if (exp_r >= EXP_OVF_TH) begin
                ovf_r  <= 1'b1;
                exp_r  <= EXP_MAX;
                mant_r <= MANT_ZERO;
              end else begin
                mant_r <= MANT_MSB;
                exp_r  <= exp_r + EXP_ONE;
              end
            end else begin
              mant_r <= round_sum_s[MW-1:0];
            end
          end
        end
`endif
        default: begin
          mant_r <= mant_r;
        end
      endcase
    end
  end

  assign out_mant = mant_r;
  assign out_exp  = exp_r;
  assign out_sgn  = sgn_r;
  assign out_zero = zero_r;
  assign out_ovf  = ovf_r;
  assign out_unf  = unf_r;

endmodule

// File: tb/tb_fadd_normalizer.sv
// Directed bench for fadd_normalizer: vector table plus stall and mid-operation reset sequences.
module tb_fadd_normalizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] in_sum;
  logic [7:0]  in_exp;
  logic        in_sgn;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_sgn;
  logic        out_zero;
  logic        out_ovf;
  logic        out_unf;

  int checks = 0;
  int errors = 0;

`ifdef FADD_NORM_ROUND_EN
  localparam int RL = 1;
`else
  localparam int RL = 0;
`endif

  always #5 clk = ~clk;

  fadd_normalizer #(.MW(16), .EW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_exp(in_exp), .in_sgn(in_sgn),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp), .out_sgn(out_sgn),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
  );

  // Truncation expectations (m/e/o) and rounded expectations (rm/re/ro).
  typedef struct {
    logic [16:0] sum;
    logic [7:0]  exp;
    logic        sgn;
    logic [15:0] m;
    logic [7:0]  e;
    logic        s;
    logic        z;
    logic        o;
    logic        u;
    int          lat;
    logic [15:0] rm;
    logic [7:0]  re;
    logic        ro;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Accept one operation and wait (bounded) for out_valid; lat=-1 on timeout.
  task automatic start_op(input logic [16:0] s, input logic [7:0] e, input logic g,
                          output int lat, output logic busy_ok);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    in_valid = 1'b1;
    in_sum   = s;
    in_exp   = e;
    in_sgn   = g;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    busy_ok  = 1'b1;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_xfer", {31'd0, in_ready}, 32'd1);
    chk("out_valid_after_xfer", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int lat;
    logic busy_ok;
    logic [15:0] em;
    logic [7:0]  ee;
    logic        eo;

    //          sum       exp     sgn  m         e      s     z     o     u    lat  rm        re     ro
    vecs[0]  = '{17'h08000, 8'd10,  1'b1, 16'h8000, 8'd10, 1'b1, 1'b0, 1'b0, 1'b0, 2,  16'h8000, 8'd10, 1'b0};
    vecs[1]  = '{17'h00001, 8'd20,  1'b0, 16'h8000, 8'd5,  1'b0, 1'b0, 1'b0, 1'b0, 17, 16'h8000, 8'd5,  1'b0};
    vecs[2]  = '{17'h10003, 8'd10,  1'b0, 16'h8001, 8'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1,  16'h8002, 8'd11, 1'b0};
    vecs[3]  = '{17'h00000, 8'd7,   1'b1, 16'h0000, 8'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1,  16'h0000, 8'd0,  1'b0};
    vecs[4]  = '{17'h10000, 8'hFF,  1'b0, 16'h0000, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1,  16'h0000, 8'hFF, 1'b1};
    vecs[5]  = '{17'h00010, 8'd3,   1'b1, 16'h0080, 8'd0,  1'b1, 1'b0, 1'b0, 1'b1, 5,  16'h0080, 8'd0,  1'b0};
    vecs[6]  = '{17'h1FFFF, 8'hFE,  1'b1, 16'h0000, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1,  16'h0000, 8'hFF, 1'b1};
    vecs[7]  = '{17'h1FFFE, 8'd4,   1'b0, 16'hFFFF, 8'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1,  16'hFFFF, 8'd5,  1'b0};
    vecs[8]  = '{17'h00C00, 8'd100, 1'b1, 16'hC000, 8'd96, 1'b1, 1'b0, 1'b0, 1'b0, 6,  16'hC000, 8'd96, 1'b0};
    vecs[9]  = '{17'h1FFFF, 8'd4,   1'b0, 16'hFFFF, 8'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1,  16'h8000, 8'd6,  1'b0};
    vecs[10] = '{17'h1FFFF, 8'hFD,  1'b1, 16'hFFFF, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0, 1,  16'h0000, 8'hFF, 1'b1};
    vecs[11] = '{17'h00001, 8'd0,   1'b0, 16'h0001, 8'd0,  1'b0, 1'b0, 1'b0, 1'b1, 2,  16'h0001, 8'd0,  1'b0};
    vecs[12] = '{17'h10001, 8'd10,  1'b1, 16'h8000, 8'd11, 1'b1, 1'b0, 1'b0, 1'b0, 1,  16'h8000, 8'd11, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = 17'd0;
    in_exp    = 8'd0;
    in_sgn    = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_mant", {16'd0, out_mant}, 32'd0);
    chk("rst_out_exp", {24'd0, out_exp}, 32'd0);
    chk("rst_flags", {28'd0, out_sgn, out_zero, out_ovf, out_unf}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
`ifdef FADD_NORM_ROUND_EN
      em = vecs[i].rm; ee = vecs[i].re; eo = vecs[i].ro;
`else
      em = vecs[i].m;  ee = vecs[i].e;  eo = vecs[i].o;
`endif
      start_op(vecs[i].sum, vecs[i].exp, vecs[i].sgn, lat, busy_ok);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat + RL);
      chk($sformatf("v%0d_mant", i), {16'd0, out_mant}, {16'd0, em});
      chk($sformatf("v%0d_exp", i), {24'd0, out_exp}, {24'd0, ee});
      chk($sformatf("v%0d_sgn", i), {31'd0, out_sgn}, {31'd0, vecs[i].s});
      chk($sformatf("v%0d_zero", i), {31'd0, out_zero}, {31'd0, vecs[i].z});
      chk($sformatf("v%0d_ovf", i), {31'd0, out_ovf}, {31'd0, eo});
      chk($sformatf("v%0d_unf", i), {31'd0, out_unf}, {31'd0, vecs[i].u});
      chk($sformatf("v%0d_busy_in_ready", i), {31'd0, busy_ok}, 32'd1);
      chk($sformatf("v%0d_done_in_ready", i), {31'd0, in_ready}, 32'd0);
      finish_op();
    end

    // Output stall: results held while out_ready stays low.
    start_op(17'h08000, 8'd10, 1'b1, lat, busy_ok);
    chk("stall_latency", lat, 2 + RL);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("stall%0d_valid", c), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stall%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
      chk($sformatf("stall%0d_mant", c), {16'd0, out_mant}, 32'h8000);
      chk($sformatf("stall%0d_exp_sgn", c), {23'd0, out_exp, out_sgn}, {23'd0, 8'd10, 1'b1});
    end
    finish_op();

    // Reset in the middle of a long normalization.
    @(negedge clk);
    in_valid = 1'b1;
    in_sum   = 17'h00001;
    in_exp   = 8'd20;
    in_sgn   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("midnorm_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_mant", {16'd0, out_mant}, 32'd0);
    chk("midrst_out_sgn", {31'd0, out_sgn}, 32'd0);

    start_op(17'h00C00, 8'd100, 1'b0, lat, busy_ok);
    chk("post_rst_latency", lat, 6 + RL);
    chk("post_rst_mant", {16'd0, out_mant}, 32'hC000);
    chk("post_rst_exp", {24'd0, out_exp}, 32'd96);
    chk("post_rst_sgn", {31'd0, out_sgn}, 32'd0);
    finish_op();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
